pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, back-pressure skid buffer, synchronous flush and bubble insertion. It replaces the fixed-field inter-stage registers, which have no stall or flush capability, with one payload-agnostic stage. Decode/execute field bundles are concatenated into `in_data`. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) and lets hazard and branch logic stall or squash a stage without per-field muxing.

## Interface
- `DATA_W`, 32: payload width in bits; must be ≥ 1.
- `NOP_VALUE`, 0: payload value driven on `out_data` whenever the stage holds a bubble; width `DATA_W`.
- `SKID`, 1: 1 = two-entry skid mode with registered `in_ready`; 0 = single-entry mode with combinational `in_ready`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `flush`  in  1  synchronous squash of all held beats.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  downstream payload; equals `NOP_VALUE` when `out_valid` = 0.
- `occupancy`  out  2  number of held beats (0..2).
- `reset_out`  out  1  high while in reset; drops on the first clock edge after reset deassertion.

## Operation
- Handshake: a beat transfers on a rising edge when valid and ready are both high. A producer holding `in_valid` must keep `in_data` stable until accepted.
- Skid-mode states (SKID=1):
  - EMPTY (occ 0).
  - FULL (main register valid, occ 1).
  - SKIDDED (main and skid registers valid, occ 2).
- Skid-mode transitions, excluding flush:
  - EMPTY + accept → FULL.
  - FULL + accept + no drain → SKIDDED. The beat goes to the skid register.
  - FULL + accept + drain → FULL. The main register loads `in_data`.
  - FULL + drain only → EMPTY.
  - SKIDDED + drain → FULL. The main register loads the skid contents.
  - In all other cases the state holds.
- Skid-mode ready: `in_ready` = state ≠ SKIDDED, driven from a register. There is no combinational path from `out_ready` to `in_ready`.
- Single-entry mode (SKID=0):
  - States are EMPTY and FULL only.
  - `in_ready` = `out_ready` OR NOT `out_valid` (combinational).
  - The skid register is not instantiated.
  - `occupancy` never exceeds 1.
- Output: `out_valid` = main register valid. `out_data` = main register, forced to `NOP_VALUE` when invalid.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush has priority over all other events in that cycle:
  - Next state is EMPTY; main and skid payloads load `NOP_VALUE`.
  - A beat that handshakes in the flush cycle (`in_valid` & `in_ready`) is discarded.
  - A beat draining in the flush cycle (`out_valid` & `out_ready`) counts as delivered.
- Reset values:
  - `out_valid` = 0, `out_data` = `NOP_VALUE`, `occupancy` = 0.
  - `in_ready` = 0 while `reset` is low, then 1 from the first edge after deassertion.
  - `reset_out` = 1.
  - State is EMPTY.
- Reset mid-operation: all held beats are lost immediately (asynchronously). There is no partial handshake completion.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N, if the stage was EMPTY or draining.
- Throughput is 1 beat/cycle when `out_ready` = 1 continuously, in both modes.
- Skid mode absorbs exactly one extra beat after `out_ready` falls. `in_ready` falls on the edge that fills the skid register.
- `in_ready` rises on the edge where SKIDDED drains to FULL.
- `occupancy` is registered and updates on the same edge as the state.
- Flush takes effect at edge N: `out_valid` = 0 immediately after N. A new beat can be accepted at edge N+1.
- `reset_out` deasserts at the first `clk` edge with `reset` high.

## Test plan
- Reset: hold `reset` low for 3 cycles with `in_valid` = 1 → `out_valid` = 0, `out_data` = `NOP_VALUE`, `in_ready` = 0, `reset_out` = 1, `occupancy` = 0. After release, `reset_out` = 0 and `in_ready` = 1 at the first edge.
- Streaming: send 0x11, 0x22, 0x33 on consecutive cycles with `out_ready` = 1 → same values appear on `out_data` one cycle later each, with `occupancy` = 1 throughout.
- Back-pressure (SKID=1):
  - Stimulus: drop `out_ready` while streaming 0xA0, 0xA1, 0xA2.
  - Holding: 0xA0 held at output, 0xA1 in skid, `occupancy` = 2, `in_ready` = 0, 0xA2 stalled.
  - Release: raise `out_ready` → output order 0xA0, 0xA1, 0xA2, with `in_ready` back to 1 one cycle after release.
- Flush in SKIDDED, with `in_valid` = 1 and data 0xBB in the flush cycle → next cycle `out_valid` = 0, `occupancy` = 0, `out_data` = `NOP_VALUE`. 0xBB never appears; the next accepted beat 0xCC emerges normally.
- Reset mid-operation: assert `reset` asynchronously between edges with `occupancy` = 2 → outputs return to reset values before the next edge, and no held beat emerges afterwards.
- Single-entry mode (SKID=0, DATA_W=8):
  - Stall: stall `out_ready` → `in_ready` = 0 in the same cycle and `occupancy` ≤ 1.
  - Flush while `out_valid` = 1 and `out_ready` = 1 → the held beat counts as delivered; no further output appears.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Payload-agnostic pipeline stage register with a valid/ready handshake,
// an optional one-entry skid buffer for back-pressure, a synchronous flush
// and bubble (NOP) insertion. Any bundle of decode/execute fields is packed
// into in_data, so hazard and branch logic can stall or squash a whole stage
// without per-field muxing.
//
// Handshake: a beat transfers on a rising clk edge when valid and ready are
// both high on that side. A producer holding in_valid keeps in_data stable
// until it is accepted. The consumer may raise or drop out_ready freely.
//
// Parameters
//   DATA_W    payload width in bits (>= 1)
//   NOP_VALUE payload driven on out_data whenever the stage holds a bubble
//   SKID      1: two-entry stage, in_ready comes straight from a flop
//             0: single-entry stage, in_ready = out_ready | ~out_valid
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   in_data    upstream payload
//   flush      synchronous squash of every held beat (wins over all else)
//   out_valid  downstream beat present
//   out_ready  downstream accepts this cycle
//   out_data   downstream payload, NOP_VALUE while out_valid is low
//   occupancy  number of held beats (0..2), registered
//   reset_out  high while in reset, drops on the first edge after release
//   state_dbg  current FSM state (0 EMPTY, 1 FULL, 2 SKIDDED)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter bit                SKID      = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic              reset_out,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FULL    = 2'd1,
      ST_SKIDDED = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_d;
   logic [DATA_W-1:0] skid_data;   // skid register contents (constant NOP when absent)
   logic [1:0]        occ_q;
   logic [1:0]        occ_d;
   logic              reset_out_q;
   logic              main_valid;
   logic              in_ready_int;
   logic              accept;
   logic              drain;

   // The main register is the output register, so its valid bit is the
   // downstream valid.
   assign main_valid = (state_q != ST_EMPTY);
   assign accept     = in_valid & in_ready_int;
   assign drain      = main_valid & out_ready;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         main_q      <= NOP_VALUE;
         occ_q       <= 2'd0;
         reset_out_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         occ_q       <= occ_d;
         reset_out_q <= 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_data;
      if (flush) begin
         // Squash everything. A beat accepted this cycle is dropped; a beat
         // draining this cycle has already been taken downstream.
         state_d = ST_EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_FULL;
                  main_d  = in_data;
               end
            end
            ST_FULL: begin
               if (accept && drain) begin
                  main_d = in_data;
               end else if (accept && SKID) begin
                  // Downstream stalled: park the new beat behind the held one.
                  state_d = ST_SKIDDED;
                  skid_d  = in_data;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKIDDED: begin
               // in_ready is low here, so only a drain can happen.
               if (drain) begin
                  state_d = ST_FULL;
                  main_d  = skid_data;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   assign occ_d = (state_d == ST_SKIDDED) ? 2'd2 :
                  (state_d == ST_FULL)    ? 2'd1 : 2'd0;

   // --------------------------------------------------------------------------
   // Skid register and ready generation
   // --------------------------------------------------------------------------
   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_q;
         logic              in_ready_q;

         // in_ready is a pure flop: it goes low on the edge that fills the
         // skid register and high on the edge that drains it, so out_ready
         // never reaches in_ready combinationally. Its reset value keeps the
         // stage closed until the first edge after reset is released.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               skid_q     <= NOP_VALUE;
               in_ready_q <= 1'b0;
            end else begin
               skid_q     <= skid_d;
               in_ready_q <= (state_d != ST_SKIDDED);
            end
         end

         assign skid_data    = skid_q;
         assign in_ready_int = in_ready_q;
      end else begin : g_single
         // Single entry: take a new beat only if the held one leaves now.
         // reset_out_q keeps the stage closed until the first edge after reset.
         assign skid_data    = NOP_VALUE;
         assign in_ready_int = ~reset_out_q & (out_ready | ~main_valid);
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      out_valid = main_valid;
      out_data  = main_valid ? main_q : NOP_VALUE;
      in_ready  = in_ready_int;
      occupancy = occ_q;
      reset_out = reset_out_q;
      state_dbg = state_q;
   end

endmodule
